mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port RAM arbiter between the instruction-fetch requester and the data requester of the pipelined MIPS core.
- Sits between the datapath/cache side and the RAM model.
- Selects one owner, holds the grant until RAM reports ACCESS, then re-arbitrates.
- Data side has priority; a bounded streak counter prevents instruction starvation.

Parameters:
- MAX_DSTREAK, 4: consecutive completed data accesses allowed while iREN is pending before instruction is forced; 0 disables the starvation guard (pure data priority).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data
- iwait  out  1  instruction stall
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data
- dwait  out  1  data stall
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- stat_igrants  out  32  completed instruction accesses
- stat_dgrants  out  32  completed data accesses

Behaviour:
- Clock and reset: single clock CLK; nRST asynchronous, active-low.
- FSM states: IDLE, IGRANT, DGRANT. Reset state is IDLE, streak=0.
- Reset output values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0. iwait=iREN and dwait=(dREN|dWEN) (combinational).
- IDLE:
  - dreq=(dREN|dWEN) and not force_i → DGRANT.
  - Else iREN → IGRANT.
  - Else stay.
  - No RAM enables are driven.
  - Grant takes effect the next cycle (1-cycle arbitration latency).
- force_i = (MAX_DSTREAK!=0) & iREN & (streak>=MAX_DSTREAK).
- DGRANT (combinational drive):
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. Write wins if both are asserted.
  - dload=ramload.
  - dwait=~(ramstate==ACCESS).
  - iwait=iREN.
- IGRANT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0.
  - iload=ramload.
  - iwait=~(ramstate==ACCESS).
  - dwait=dreq.
- Completion: ramstate==ACCESS in a grant state. Next state is chosen by the IDLE rules evaluated in the same cycle, so back-to-back grants need no idle cycle.
- Streak counter:
  - Data completion with iREN high: streak+1, saturating at MAX_DSTREAK.
  - Data completion with iREN low: streak unchanged.
  - Instruction completion: streak=0.
- FREE/BUSY/ERROR in a grant state: hold grant and enables; owner wait stays 1. ERROR is retried indefinitely.
- Owner drops its request mid-grant:
  - RAM enables fall the same cycle (combinational).
  - FSM → IDLE next edge.
  - No completion is counted.
- Outputs not listed for a state are 0; the non-owner's load bus is 0.
- Reset mid-access: FSM returns to IDLE immediately and the enables drop asynchronously. The requester re-issues.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: stat_igrants and stat_dgrants increment on each completion of their side. They wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- cpu_types_pkg holds ramstate_t (existing) and the new arb_state_t enum {IDLE, IGRANT, DGRANT}.
- One sub-module, arb_streak_counter: saturating counter with inc/clr/limit compare, outputting force_i.
- Stats counters stay inline.

Test Plan:
- Reset with iREN=1, ramstate=FREE → state IDLE, ramREN=0, iwait=1. After release: IGRANT next cycle, ramaddr=iaddr.
- Simultaneous iREN=1 and dREN=1, daddr=0x100, RAM ACCESS after 2 BUSY cycles:
  - DGRANT first; dwait=0 and dload=ramload on the ACCESS cycle.
  - Next cycle is IGRANT if dREN has dropped.
- Continuous dWEN plus iREN, MAX_DSTREAK=4, each access ACCESS after 1 cycle → exactly 4 data completions, then 1 instruction grant, then streak resets.
- dREN=dWEN=1, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- ramstate=ERROR for 3 cycles then ACCESS during IGRANT → grant held, iwait=1 for 3 cycles, completion on cycle 4, stat_igrants +1 (with MEM_ARBITER_STATS_EN).
- Requester drops dREN mid-DGRANT, then nRST is pulsed low mid-IGRANT:
  - Enables drop the same cycle and the FSM returns to IDLE with no stat increment.
  - Reset asynchronously forces IDLE and ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined MIPS core memory subsystem.
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : ownership state of the instruction/data RAM arbiter
// ----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the cache-side request/response signals and the RAM-side signals
// handled by mem_arbiter.
//   master : the arbiter's view (drives loads, waits and RAM controls)
//   slave  : the environment's view (requesters plus RAM model)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // instruction requester
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  // data requester
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_streak_counter.sv
// ----------------------------------------------------------------------------
// arb_streak_counter
// Counts consecutive data completions that happened while an instruction
// fetch was waiting, and raises o_force_i once the limit is reached so the
// arbiter hands the RAM to the instruction side.
//   CLK, nRST : clock, asynchronous active-low reset
//   i_inc     : a data access completes this cycle
//   i_clr     : an instruction access completes this cycle
//   i_req     : instruction request pending (iREN)
//   o_force_i : instruction side must win the next arbitration
// LIMIT = 0 disables the guard (o_force_i stays low).
// ----------------------------------------------------------------------------
module arb_streak_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_req,
  output logic o_force_i
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_streak;
  logic [W-1:0] w_streak_next;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_streak_next = r_streak;
    if (i_clr) begin
      w_streak_next = '0;
    end else if (i_inc && i_req && (r_streak < LIM)) begin
      w_streak_next = r_streak + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_next;
    end
  end

  // Judged on the post-update count: the completion that reaches the limit
  // already steers the same-cycle re-arbitration toward the instruction side.
  assign o_force_i = (LIMIT != 0) && i_req && (w_streak_next >= LIM);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Single-port RAM arbiter between instruction fetch and data access of the
// pipelined MIPS core. Data has priority; a bounded streak counter stops the
// instruction side from starving. A grant is held until the RAM reports
// ACCESS, then the next owner is chosen in the same cycle.
//   CLK, nRST    : clock (rising edge), asynchronous active-low reset
//   bus          : mem_arbiter_if.master (requester and RAM signals)
//   stat_igrants : completed instruction accesses
//   stat_dgrants : completed data accesses
// Optional: define MEM_ARBITER_STATS_EN to build the completion counters;
// without it both stat ports are tied to 0.
// ----------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus,
  output logic [31:0]   stat_igrants,
  output logic [31:0]   stat_dgrants
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  arb_state_t w_arb_next;
  logic       w_dreq;
  logic       w_access;
  logic       w_i_done;
  logic       w_d_done;
  logic       w_force_i;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == ACCESS);
  assign w_i_done = (r_state == IGRANT) & bus.iREN & w_access;
  assign w_d_done = (r_state == DGRANT) & w_dreq & w_access;

  arb_streak_counter #(
    .LIMIT (MAX_DSTREAK)
  ) u_streak (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_inc     (w_d_done),
    .i_clr     (w_i_done),
    .i_req     (bus.iREN),
    .o_force_i (w_force_i)
  );

  // Who would own the RAM next if it were free right now.
  always_comb begin
    w_arb_next = IDLE;
    if (w_dreq && !w_force_i) begin
      w_arb_next = DGRANT;
    end else if (bus.iREN) begin
      w_arb_next = IGRANT;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = w_arb_next;
      IGRANT: begin
        if (!bus.iREN)    w_next_state = IDLE;
        else if (w_access) w_next_state = w_arb_next;
      end
      DGRANT: begin
        if (!w_dreq)       w_next_state = IDLE;
        else if (w_access) w_next_state = w_arb_next;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // RAM controls and load buses are purely combinational from the grant, so
  // a dropped request or an asynchronous reset removes the enables at once.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = w_dreq;
    case (r_state)
      IGRANT: begin
        if (bus.iREN) begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
          bus.iload   = bus.ramload;
          bus.iwait   = ~w_access;
        end
      end
      DGRANT: begin
        if (w_dreq) begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          // a write request overrides a simultaneous read request
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.dload    = bus.ramload;
          bus.dwait    = ~w_access;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] r_stat_i;
  logic [31:0] r_stat_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
    end else begin
      if (w_i_done) r_stat_i <= r_stat_i + 32'd1;
      if (w_d_done) r_stat_d <= r_stat_d + 32'd1;
    end
  end

  assign stat_igrants = r_stat_i;
  assign stat_dgrants = r_stat_d;
`else
  assign stat_igrants = '0;
  assign stat_dgrants = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus for mem_arbiter. Every expected RAM completion is queued
// when the stimulus sets it up; a negedge monitor pops and compares whenever
// the DUT signals a completion (owner wait low while requesting).
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_i = 0;
  int   exp_d = 0;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] stat_igrants;
  logic [31:0] stat_dgrants;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_DSTREAK (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .bus          (bus),
    .stat_igrants (stat_igrants),
    .stat_dgrants (stat_dgrants)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_i(input logic [31:0] addr, input logic [31:0] load);
    sb_q.push_back('{1'b0, addr, 1'b0, 1'b1, 32'h0, load});
    exp_i++;
  endtask

  task automatic push_d(input logic [31:0] addr, input logic wen, input logic ren,
                        input logic [31:0] store, input logic [31:0] load);
    sb_q.push_back('{1'b1, addr, wen, ren, store, load});
    exp_d++;
  endtask

  task automatic check_stats();
`ifdef MEM_ARBITER_STATS_EN
    check("stat_igrants", stat_igrants, exp_i);
    check("stat_dgrants", stat_dgrants, exp_d);
`else
    check("stat_igrants_tied", stat_igrants, 32'h0);
    check("stat_dgrants_tied", stat_dgrants, 32'h0);
`endif
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor
  logic i_c, d_c;
  exp_t e;
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      i_c = bus.iREN & ~bus.iwait;
      d_c = (bus.dREN | bus.dWEN) & ~bus.dwait;
      if (i_c || d_c) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: completion i=%0b d=%0b addr=%h, none expected (t=%0t)",
                   i_c, d_c, bus.ramaddr, $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_side_is_data", {31'h0, d_c}, {31'h0, e.is_d});
          check("sb_ramaddr", bus.ramaddr, e.addr);
          check("sb_ramWEN", {31'h0, bus.ramWEN}, {31'h0, e.wen});
          check("sb_ramREN", {31'h0, bus.ramREN}, {31'h0, e.ren});
          check("sb_ramstore", bus.ramstore, e.store);
          check("sb_load", e.is_d ? bus.dload : bus.iload, e.load);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, s;
    nRST         = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h400;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramstate = FREE;

    // reset state with an instruction request pending
    mid();
    check("rst_ramREN", {31'h0, bus.ramREN}, 32'h0);
    check("rst_ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    check("rst_iload", bus.iload, 32'h0);
    check("rst_dload", bus.dload, 32'h0);
    check("rst_iwait", {31'h0, bus.iwait}, 32'h1);
    check("rst_dwait", {31'h0, bus.dwait}, 32'h0);
    check_stats();
    #1 nRST = 1'b1;
    cyc();

    // first cycle after release: instruction granted
    mid();
    check("igrant_ramREN", {31'h0, bus.ramREN}, 32'h1);
    check("igrant_ramaddr", bus.ramaddr, 32'h400);
    check("igrant_ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    check("igrant_iwait", {31'h0, bus.iwait}, 32'h1);
    cyc();

    // ERROR for 3 cycles: grant held
    bus.ramstate = ERROR;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("err_iwait", {31'h0, bus.iwait}, 32'h1);
      check("err_ramREN", {31'h0, bus.ramREN}, 32'h1);
      check("err_ramaddr", bus.ramaddr, 32'h400);
      cyc();
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hA5A5_0400;
    push_i(32'h400, 32'hA5A5_0400);
    mid();
    cyc();

    // instruction side drops its request: enables fall immediately
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    mid();
    check("idrop_ramREN", {31'h0, bus.ramREN}, 32'h0);
    check("idrop_iwait", {31'h0, bus.iwait}, 32'h0);
    check_stats();
    cyc();

    // simultaneous requests from IDLE: data wins
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h404;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    mid();
    check("idle_ramREN", {31'h0, bus.ramREN}, 32'h0);
    check("idle_iwait", {31'h0, bus.iwait}, 32'h1);
    check("idle_dwait", {31'h0, bus.dwait}, 32'h1);
    cyc();
    bus.ramstate = BUSY;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("dgrant_ramaddr", bus.ramaddr, 32'h100);
      check("dgrant_ramREN", {31'h0, bus.ramREN}, 32'h1);
      check("dgrant_dwait", {31'h0, bus.dwait}, 32'h1);
      check("dgrant_iwait", {31'h0, bus.iwait}, 32'h1);
      check("dgrant_iload_zero", bus.iload, 32'h0);
      cyc();
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0000_BEEF;
    push_d(32'h100, 1'b0, 1'b1, 32'h0, 32'h0000_BEEF);
    mid();
    check("dacc_iload_zero", bus.iload, 32'h0);
    cyc();

    // data drops its request mid-grant: no completion counted
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    mid();
    check("ddrop_ramREN", {31'h0, bus.ramREN}, 32'h0);
    check("ddrop_ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    check("ddrop_dwait", {31'h0, bus.dwait}, 32'h0);
    check("ddrop_dload", bus.dload, 32'h0);
    check_stats();
    cyc();
    mid();
    check("back_idle_ramREN", {31'h0, bus.ramREN}, 32'h0);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0404_0404;
    push_i(32'h404, 32'h0404_0404);
    mid();
    check("igrant2_ramaddr", bus.ramaddr, 32'h404);
    cyc();

    // back-to-back instruction completion, then data write+read streak
    bus.iaddr   = 32'h408;
    bus.dREN    = 1'b1;
    bus.dWEN    = 1'b1;
    bus.daddr   = 32'h200;
    bus.dstore  = 32'hDEAD_BEEF;
    bus.ramload = 32'h0408_0408;
    push_i(32'h408, 32'h0408_0408);
    mid();
    cyc();
    for (int k = 0; k < 4; k++) begin
      a = 32'h200 + 32'(4 * k);
      s = (k == 0) ? 32'hDEAD_BEEF : 32'h1000 + 32'(k);
      bus.daddr    = a;
      bus.dstore   = s;
      bus.dREN     = (k == 0);
      bus.ramstate = BUSY;
      bus.ramload  = 32'h0;
      mid();
      check("wr_ramWEN", {31'h0, bus.ramWEN}, 32'h1);
      check("wr_ramREN", {31'h0, bus.ramREN}, 32'h0);
      check("wr_ramstore", bus.ramstore, s);
      check("wr_ramaddr", bus.ramaddr, a);
      check("wr_dwait", {31'h0, bus.dwait}, 32'h1);
      cyc();
      bus.ramstate = ACCESS;
      bus.ramload  = 32'hCC00 + 32'(k);
      push_d(a, 1'b1, 1'b0, s, 32'hCC00 + 32'(k));
      mid();
      cyc();
    end
    // streak limit reached: instruction forced in
    bus.iaddr    = 32'h40C;
    bus.dREN     = 1'b0;
    bus.daddr    = 32'h300;
    bus.dstore   = 32'h3003;
    bus.ramstate = BUSY;
    bus.ramload  = 32'h0;
    mid();
    check("forced_ramaddr", bus.ramaddr, 32'h40C);
    check("forced_ramREN", {31'h0, bus.ramREN}, 32'h1);
    check("forced_ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    check("forced_ramstore", bus.ramstore, 32'h0);
    check("forced_dwait", {31'h0, bus.dwait}, 32'h1);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h040C_040C;
    push_i(32'h40C, 32'h040C_040C);
    mid();
    cyc();
    // streak cleared: data wins again and keeps the grant after completing
    bus.ramstate = BUSY;
    bus.ramload  = 32'h0;
    mid();
    check("post_ramaddr", bus.ramaddr, 32'h300);
    check("post_ramWEN", {31'h0, bus.ramWEN}, 32'h1);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h3300;
    push_d(32'h300, 1'b1, 1'b0, 32'h3003, 32'h3300);
    mid();
    cyc();
    bus.daddr    = 32'h304;
    bus.dstore   = 32'h3004;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    mid();
    check("streak_reset_ramaddr", bus.ramaddr, 32'h304);
    check("streak_reset_ramWEN", {31'h0, bus.ramWEN}, 32'h1);
    check("streak_reset_iwait", {31'h0, bus.iwait}, 32'h1);
    check_stats();
    cyc();

    // data drops, instruction granted, then reset pulse mid-grant
    bus.dWEN  = 1'b0;
    bus.iaddr = 32'h500;
    mid();
    check("ddrop2_ramWEN", {31'h0, bus.ramWEN}, 32'h0);
    check("ddrop2_ramREN", {31'h0, bus.ramREN}, 32'h0);
    cyc();
    mid();
    cyc();
    mid();
    check("igrant500_ramREN", {31'h0, bus.ramREN}, 32'h1);
    check("igrant500_ramaddr", bus.ramaddr, 32'h500);
    #1 nRST = 1'b0;
    exp_i = 0;
    exp_d = 0;
    #1;
    check("arst_ramREN", {31'h0, bus.ramREN}, 32'h0);
    check("arst_ramaddr", bus.ramaddr, 32'h0);
    check("arst_iwait", {31'h0, bus.iwait}, 32'h1);
    check_stats();
    #1 nRST = 1'b1;
    cyc();
    mid();
    check("reissue_ramREN", {31'h0, bus.ramREN}, 32'h1);
    check("reissue_ramaddr", bus.ramaddr, 32'h500);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0500_0500;
    push_i(32'h500, 32'h0500_0500);
    mid();
    cyc();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    mid();
    check_stats();
    cyc();
    mid();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
